sram_controller: RTL

- Serves the cache controller's SRAM request interface.
- Converts a 32-bit word write, or a 64-bit block read, into a sequence of 16-bit accesses on the board's external asynchronous SRAM.
- Inserts programmable wait states per access and signals completion with a one-cycle ready pulse.
- Sits between the cache controller and the top-level SRAM pins; the top level builds the tri-state DQ from the split dq ports.

---
 rtl/sram_controller_pkg.sv | 22 ++
 rtl/sram_slot_counter.sv | 44 ++++
 rtl/sram_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants for the cache-side SRAM controller: FSM encoding, memory base
// and per-transaction halfword counts.
package sram_controller_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;

  localparam int unsigned WRITE_HALFWORDS = 2;
  localparam int unsigned READ_HALFWORDS  = 4;

  typedef logic [1:0] state_t;

  // Selects the low (h=0) or high (h=1) halfword of a 32-bit word.
  function automatic logic [15:0] halfword_sel(input logic [31:0] word, input logic h);
    return h ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/sram_slot_counter.sv
// Walks a transaction through its 16-bit slots: WAIT_CYCLES strobe cycles plus
// one hold cycle per slot, advancing the halfword index at each slot boundary.
module sram_slot_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic [2:0] num_slots,
  output logic       slot_last,
  output logic       strobe_active,
  output logic [1:0] hw_idx,
  output logic       all_done
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CNT_W-1:0] slot_cnt_reg;
  logic [1:0]       hw_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_reg <= '0;
      hw_reg       <= '0;
    end else if (start) begin
      slot_cnt_reg <= '0;
      hw_reg       <= '0;
    end else if (run) begin
      if (slot_last) begin
        slot_cnt_reg <= '0;
        hw_reg       <= hw_reg + 2'd1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
    end
  end

  assign slot_last     = (slot_cnt_reg == CNT_W'(WAIT_CYCLES));
  assign strobe_active = (slot_cnt_reg <  CNT_W'(WAIT_CYCLES));
  assign hw_idx        = hw_reg;
  assign all_done      = slot_last && ({1'b0, hw_reg} == (num_slots - 3'd1));

endmodule

// File: rtl/sram_controller.sv
// Cache-side controller for the external asynchronous SRAM: one 32-bit word
// write or one 64-bit block read, split into 16-bit slots with wait states.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic              read,
  input  logic              write,
  output logic [63:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  state_t            state_reg, state_next;
  logic [ADDR_W-2:0] word_idx_reg;
  logic [31:0]       wdata_reg;
  logic [63:0]       rdata_reg;
  logic              ready_reg;

  logic [31:0]       offset;
  logic [ADDR_W-2:0] word_idx;
  logic              accept, run;
  logic [2:0]        num_slots;
  logic              slot_last, strobe_active, all_done;
  logic [1:0]        hw_idx;
  logic              unused_offset_bits;

  // Addresses below the base wrap modulo the SRAM size rather than faulting.
  assign offset             = address - BASE_ADDR;
  assign word_idx           = offset[ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  assign accept    = (state_reg == ST_IDLE) && (read || write);
  assign run       = (state_reg == ST_WRITE) || (state_reg == ST_READ);
  assign num_slots = (state_reg == ST_READ) ? 3'(READ_HALFWORDS) : 3'(WRITE_HALFWORDS);

  sram_slot_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_slot_counter (
    .clk          (clk),
    .rst          (rst),
    .start        (accept),
    .run          (run),
    .num_slots    (num_slots),
    .slot_last    (slot_last),
    .strobe_active(strobe_active),
    .hw_idx       (hw_idx),
    .all_done     (all_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (write)     state_next = ST_WRITE;
        else if (read) state_next = ST_READ;
      end
      ST_WRITE, ST_READ: begin
        if (all_done) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      word_idx_reg <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= run && all_done;
      if (accept) begin
        // Block reads always start on the even word of the pair.
        word_idx_reg <= write ? word_idx : {word_idx[ADDR_W-2:1], 1'b0};
        wdata_reg    <= wdata;
      end
      if ((state_reg == ST_READ) && slot_last) begin
        rdata_reg[{hw_idx, 4'b0000} +: 16] <= sram_dq_in;
      end
    end
  end

  assign sram_addr   = run ? ({word_idx_reg, 1'b0} + ADDR_W'(hw_idx)) : '0;
  assign sram_dq_out = (state_reg == ST_WRITE) ? halfword_sel(wdata_reg, hw_idx[0]) : 16'h0000;
  assign sram_dq_oe  = (state_reg == ST_WRITE);
  // The final cycle of each write slot keeps address and data stable after the strobe.
  assign sram_we_n   = !((state_reg == ST_WRITE) && strobe_active);
  assign sram_oe_n   = !(state_reg == ST_READ);
  assign sram_ce_n   = 1'b0;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;
  assign rdata       = rdata_reg;
  assign ready       = ready_reg;

endmodule
